lcrc_32: RTL and testbench
==========================

# lcrc_32

Link CRC generator for PCIe-style packet protection. Repeatedly samples a WIDTH-bit data word, computes its standard CRC-32 bit-serially and presents the data word concatenated with its 32-bit LCRC on a registered output. It sits between the TLP payload source and the replay buffer, where the protected word is stored for transmission and retry.

## Interface
- WIDTH, default 8: data word width in bits; any value ≥ 1.
- clk  input  1: single clock; all state updates on the rising edge.
- reset  input  1: asynchronous, active-high reset.
- in  input  WIDTH: data word to protect; sampled only in the LOAD state.
- final_out  output  WIDTH+32: registered result; final_out[WIDTH+31:32] is the sampled data and final_out[31:0] is its LCRC.
- Positional port order is in, reset, clk, final_out.
- One clock; reset is asynchronous and active-high.

## Operation
- CRC definition: reflected CRC-32 with polynomial 0x04C11DB7 (reflected constant 0xEDB88320). Seed is 0xFFFFFFFF, data is consumed LSB first, and the result is the final register XOR 0xFFFFFFFF. This is identical to Ethernet/zlib CRC-32 over the byte stream when WIDTH=8.
- Internal state:
  - crc register, 32 bits.
  - data register, WIDTH bits.
  - bit counter, sized for 0..WIDTH-1.
  - 2-bit FSM state.
- FSM states and transitions:
  - LOAD: data <= in, crc <= 0xFFFFFFFF, counter <= 0; next state is SHIFT.
  - SHIFT: fb = crc[0] ^ data[counter]; crc <= (crc >> 1) ^ (fb ? 0xEDB88320 : 0); counter increments. After the edge that processes bit WIDTH-1, the next state is DONE.
  - DONE: final_out <= {data, ~crc}; next state is LOAD.
- The machine free-runs with no handshake. The block recomputes continuously; a constant input yields a constant final_out after the first frame.
- Changes on in outside the LOAD sampling edge do not affect the frame in progress.
- final_out changes only in DONE and holds its value between updates.
- Reset, asynchronous at any time including mid-frame:
  - state = LOAD, crc = 0xFFFFFFFF, data = 0, counter = 0, final_out = 0.
  - A partially computed frame is discarded.
- The first LOAD happens on the first rising edge after reset deasserts.
- Reset must be applied once before the output is valid. Without reset, state and output are undefined.

## Timing
- Frame period is WIDTH+2 clocks: 1 LOAD, WIDTH SHIFT, 1 DONE. For WIDTH=8 this is 10 clocks.
- Latency: final_out reflects the in value sampled at LOAD edge k on edge k+WIDTH+1.
- First valid final_out appears on the (WIDTH+2)th rising edge after reset release. Before that, final_out reads 0.
- Consecutive samples occur every WIDTH+2 edges.
- No combinational path from in to final_out.

## Test plan
- Reset check: assert reset mid-clock, asynchronously -> final_out = 0 immediately, without waiting for a clock edge.
- Baseline frame: WIDTH=8, in=0x55 held, reset released -> final_out = 0x55_C9034AF6 on the 10th edge; value unchanged on all subsequent frames.
- All-zero data: in=0x00 -> final_out = 0x00_D202EF8D.
- All-ones data: in=0xFF -> final_out = 0x FF_FF000000.
- Sampling point: in=0x55 at the LOAD edge, changed to 0x00 during SHIFT -> that frame still yields 0x55_C9034AF6; the next frame yields 0x00_D202EF8D.
- Mid-frame reset: pulse reset during SHIFT -> final_out = 0. A full frame period after release, the correct value for the current in is shown; no stale partial CRC appears.

Source files
------------

// File: rtl/lcrc_32.sv
// lcrc_32: bit-serial link CRC generator.
// Free-running frame: LOAD samples the data word, SHIFT runs one CRC-32
// step per clock (LSB first, reflected poly 0xEDB88320, seed all ones),
// and DONE publishes {data, ~crc} on the registered output.
// Frame period is WIDTH+2 clocks. There is no handshake: final_out is
// rewritten once per frame and holds its value in between.
module lcrc_32 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]  in,
    input  logic              reset,
    input  logic              clk,
    output logic [WIDTH+31:0] final_out
);

    // A 1-bit counter is still needed when WIDTH is 1.
    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);
    localparam logic [31:0]     POLY_REF = 32'hEDB88320;
    localparam logic [31:0]     CRC_SEED = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [31:0]        r_crc;
    logic [WIDTH-1:0]   r_data;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH+31:0]  r_out;

    // Feedback bit for the current serial step: CRC LSB against the data bit.
    logic w_fb;
    assign w_fb = r_crc[0] ^ r_data[r_cnt];

    // Frame sequencer: sample, shift WIDTH bits, publish, repeat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_LOAD;
            r_crc   <= CRC_SEED;
            r_data  <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_data  <= in;
                    r_crc   <= CRC_SEED;
                    r_cnt   <= '0;
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    r_crc <= (r_crc >> 1) ^ (w_fb ? POLY_REF : 32'h0);
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_BIT) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_out   <= {r_data, ~r_crc};
                    r_state <= ST_LOAD;
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    assign final_out = r_out;

endmodule

// File: tb/tb_lcrc_32.sv
// tb_lcrc_32: directed vectors for lcrc_32 (WIDTH=8) with a scoreboard.
// The driver pushes the hand-computed result when it presents a word for
// the LOAD edge; the monitor pops on every DONE edge and, on all other
// edges, checks that final_out holds the last published value.
module tb_lcrc_32;

    localparam int WIDTH  = 8;
    localparam int PERIOD = WIDTH + 2;

    localparam logic [39:0] EXP_55 = 40'h55_C9034AF6;
    localparam logic [39:0] EXP_00 = 40'h00_D202EF8D;
    localparam logic [39:0] EXP_FF = 40'hFF_FF000000;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [WIDTH-1:0]  in_d = '0;
    logic [WIDTH+31:0] final_out;

    lcrc_32 #(.WIDTH(WIDTH)) dut (
        .in        (in_d),
        .reset     (reset),
        .clk       (clk),
        .final_out (final_out)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int             n_tests = 0;
    int             n_fail  = 0;
    logic [39:0]    exp_q[$];
    logic [39:0]    last_exp = '0;
    bit             checking = 1'b0;
    int             phase = 0;      // frame phase of the next rising edge
    int             mon_p = 0;
    logic [39:0]    mon_e;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame phase follows the timing contract: edge 0 after release is LOAD,
    // edge PERIOD-1 is DONE.
    always @(posedge clk or posedge reset) begin
        if (reset) phase <= 0;
        else       phase <= (phase == PERIOD - 1) ? 0 : phase + 1;
    end

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        mon_p = phase;
        #1;
        if (checking && !reset) begin
            if (mon_p == PERIOD - 1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL frame_no_expect: got %h expected none at %0t", final_out, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("frame", final_out, mon_e);
                    last_exp = mon_e;
                end
            end else begin
                check("hold", final_out, last_exp);
            end
        end
    end

    // ---------------- driver ----------------
    // Called at a falling edge; presents d ahead of the next LOAD edge and,
    // optionally, changes in to g during SHIFT of that same frame.
    task automatic frame(input logic [7:0] d, input logic [39:0] e,
                         input bit glitch, input logic [7:0] g);
        while (phase != 0) @(negedge clk);
        in_d = d;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (glitch) in_d = g;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Asynchronous reset mid-cycle: output clears without a clock edge.
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset", final_out, 40'h0);
        repeat (2) @(negedge clk);
        in_d     = 8'h55;
        checking = 1'b1;
        reset    = 1'b0;

        // Baseline: 0x55 held, result repeats every frame.
        repeat (3) frame(8'h55, EXP_55, 1'b0, 8'h00);
        repeat (2) frame(8'h00, EXP_00, 1'b0, 8'h00);
        repeat (2) frame(8'hFF, EXP_FF, 1'b0, 8'h00);

        // Sampling point: change during SHIFT must not affect the frame.
        frame(8'h55, EXP_55, 1'b1, 8'h00);
        frame(8'h00, EXP_00, 1'b0, 8'h00);
        frame(8'hFF, EXP_FF, 1'b0, 8'h00);

        // Mid-frame reset: start a 0x00 frame, kill it during SHIFT.
        while (phase != 0) @(negedge clk);
        in_d = 8'h00;
        exp_q.push_back(EXP_00);
        @(posedge clk);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1 check("midframe_reset", final_out, 40'h0);
        exp_q.delete();
        last_exp = '0;
        @(negedge clk);
        in_d  = 8'h55;
        reset = 1'b0;
        repeat (2) frame(8'h55, EXP_55, 1'b0, 8'h00);

        // Drain: every pushed expectation must have been consumed.
        repeat (PERIOD + 4) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
